// File: rtl/segment_display_ctrl.sv
// rtl/segment_display_ctrl.sv - valid/ready fed N-digit 7-segment driver, decimal (double-dabble) or hex
module segment_display_ctrl #(
  parameter int N_DIGITS = 6,
  parameter int VALUE_W  = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VALUE_W-1:0]    in_value,
  input  logic                  in_hex_mode,
  input  logic                  in_blank_lz,
  output logic                  busy,
  output logic                  overflow,
  output logic [7*N_DIGITS-1:0] seg_out
);

  localparam int BW = 4 * N_DIGITS;
  localparam int CW = $clog2(VALUE_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  state_t                state, state_nxt;
  logic [VALUE_W-1:0]    val_q;
  logic                  hex_q, blz_q, ovf_q;
  logic [BW-1:0]         bcd_q, bcd_adj, digits;
  logic [CW-1:0]         cnt_q;
  logic [7*N_DIGITS-1:0] seg_nxt;
  logic                  seen;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0-F
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0011000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: decimal goes through VALUE_W shift cycles, hex goes straight to UPDATE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = in_hex_mode ? UPDATE : CONV;
      CONV:    if (cnt_q == CW'(VALUE_W - 1)) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs follow the state directly
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

  // Double-dabble add-3 correction applied before every shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
  end

  // Capture on handshake, then shift MSB-first into the BCD register while converting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_q <= '0;
      hex_q <= 1'b0;
      blz_q <= 1'b0;
      ovf_q <= 1'b0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          val_q <= in_value;
          hex_q <= in_hex_mode;
          blz_q <= in_blank_lz;
          ovf_q <= 1'b0;
          bcd_q <= '0;
          cnt_q <= '0;
        end
        CONV: begin
          bcd_q <= {bcd_adj[BW-2:0], val_q[VALUE_W-1]};
          ovf_q <= ovf_q | bcd_adj[BW-1];
          val_q <= val_q << 1;
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Per-digit glyph selection: overflow, invalid BCD, leading-zero blanking, normal
  always_comb begin
    digits  = hex_q ? BW'(val_q) : bcd_q;
    seen    = 1'b0;
    seg_nxt = '1;
    for (int d = N_DIGITS - 1; d >= 0; d--) begin
      if (digits[4*d +: 4] != 4'd0) seen = 1'b1;
      if (!hex_q && ovf_q)                       seg_nxt[7*d +: 7] = 7'b0000110;
      else if (!hex_q && digits[4*d +: 4] > 4'd9) seg_nxt[7*d +: 7] = 7'b0000110;
      else if (blz_q && !seen && d != 0)         seg_nxt[7*d +: 7] = 7'b1111111;
      else                                       seg_nxt[7*d +: 7] = seg7(digits[4*d +: 4]);
    end
  end

  // Display registers load only on the UPDATE edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_out  <= '1;
      overflow <= 1'b0;
    end else if (state == UPDATE) begin
      seg_out  <= seg_nxt;
      overflow <= !hex_q && ovf_q;
    end
  end

endmodule

// File: tb/tb_segment_display_ctrl.sv
// tb/tb_segment_display_ctrl.sv - directed self-checking bench for segment_display_ctrl
module tb_segment_display_ctrl;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010;
  localparam logic [6:0] SA = 7'b0001000, SB = 7'b0000011, SC = 7'b1000110, SD = 7'b0100001;
  localparam logic [6:0] SE = 7'b0000110, BL = 7'b1111111;
  localparam logic [41:0] ALL1 = {42{1'b1}};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] in_value = '0;
  logic        in_hex_mode = 1'b0;
  logic        in_blank_lz = 1'b0;
  logic        busy;
  logic        overflow;
  logic [41:0] seg_out;

  int n_pass = 0;
  int n_total = 0;
  int lat;
  logic [41:0] seg_e0;
  logic [41:0] exp_b2b [3];
  logic [19:0] vals_b2b [3];

  segment_display_ctrl #(.N_DIGITS(6), .VALUE_W(20)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_hex_mode(in_hex_mode), .in_blank_lz(in_blank_lz),
    .busy(busy), .overflow(overflow), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a negedge with in_ready=1; returns cycles spent busy after the handshake
  task automatic send(input logic [19:0] v, input logic hx, input logic bl,
                      output int cycles, output logic [41:0] seg_first);
    in_valid = 1'b1; in_value = v; in_hex_mode = hx; in_blank_lz = bl;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_value = 20'hFFFFF; in_hex_mode = ~hx; in_blank_lz = ~bl;
    seg_first = seg_out;
    cycles = 0;
    while (!in_ready && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    // Reset state, held and after release
    repeat (3) @(negedge clk);
    chk("rst_seg", seg_out, ALL1);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_seg", seg_out, ALL1);
    chk("idle_ready", in_ready, 1'b1);

    // Decimal 123456, no blanking
    send(20'd123456, 1'b0, 1'b0, lat, seg_e0);
    chk("dec_lat", lat, 21);
    chk("dec_seg", seg_out, {S1, S2, S3, S4, S5, S6});
    chk("dec_ovf", overflow, 1'b0);

    // Hex 0xABCDE; inputs scrambled after the handshake must be ignored
    send(20'hABCDE, 1'b1, 1'b0, lat, seg_e0);
    chk("hex_hold", seg_e0, {S1, S2, S3, S4, S5, S6});
    chk("hex_lat", lat, 1);
    chk("hex_seg", seg_out, {S0, SA, SB, SC, SD, SE});
    chk("hex_ovf", overflow, 1'b0);

    // Decimal overflow
    send(20'd1048575, 1'b0, 1'b0, lat, seg_e0);
    chk("ovf_lat", lat, 21);
    chk("ovf_seg", seg_out, {SE, SE, SE, SE, SE, SE});
    chk("ovf_flag", overflow, 1'b1);

    // Leading-zero blanking clears overflow
    send(20'd42, 1'b0, 1'b1, lat, seg_e0);
    chk("lz42_seg", seg_out, {BL, BL, BL, BL, S4, S2});
    chk("lz42_ovf", overflow, 1'b0);
    send(20'd0, 1'b0, 1'b1, lat, seg_e0);
    chk("lz0_seg", seg_out, {BL, BL, BL, BL, BL, S0});

    // Reset in the middle of a conversion
    in_valid = 1'b1; in_value = 20'd777777; in_hex_mode = 1'b0; in_blank_lz = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("abort_seg", seg_out, ALL1);
    chk("abort_ready", in_ready, 1'b1);
    chk("abort_ovf", overflow, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(20'd5, 1'b0, 1'b0, lat, seg_e0);
    chk("post_lat", lat, 21);
    chk("post_seg", seg_out, {S0, S0, S0, S0, S0, S5});

    // Back-to-back with in_valid held high
    vals_b2b[0] = 20'd1; vals_b2b[1] = 20'd2; vals_b2b[2] = 20'd3;
    exp_b2b[0] = {BL, BL, BL, BL, BL, S1};
    exp_b2b[1] = {BL, BL, BL, BL, BL, S2};
    exp_b2b[2] = {BL, BL, BL, BL, BL, S3};
    in_hex_mode = 1'b0; in_blank_lz = 1'b1;
    in_valid = 1'b1; in_value = vals_b2b[0];
    for (int k = 0; k < 3; k++) begin
      chk("b2b_ready", in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      if (k < 2) in_value = vals_b2b[k + 1];
      else in_valid = 1'b0;
      lat = 0;
      while (!in_ready && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      chk("b2b_lat", lat, 21);
      chk("b2b_seg", seg_out, exp_b2b[k]);
    end
    repeat (30) @(negedge clk);
    chk("b2b_done_ready", in_ready, 1'b1);
    chk("b2b_done_seg", seg_out, exp_b2b[2]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
